// File: rtl/univ_shreg_pkg.sv
// Package for the universal shift register.
//   mode_t  : per-edge operation selected by the mode input (2 bits).
//   state_t : serialisation control state (IDLE, LOADED, FULL).
// Shared by shreg_cell and univ_shreg.
package univ_shreg_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHL  = 2'b01,
    SHR  = 2'b10,
    LOAD = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOADED = 2'b01,
    FULL   = 2'b10
  } state_t;

  // Width of a counter that must be able to hold the value w.
  function automatic int count_bits(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shreg_cell.sv
// One bit of the universal shift register.
// Enabled D cell with synchronous active-high reset and a 4:1 next-value mux.
// Ports:
//   clock   : clock, updates on posedge
//   reset   : synchronous active-high reset, clears q
//   enable  : 1 = apply mode this edge, 0 = hold
//   mode    : HOLD / SHL / SHR / LOAD
//   d       : parallel load value for this bit
//   shl_in  : value this bit takes on SHL (lower neighbour or serial-in)
//   shr_in  : value this bit takes on SHR (upper neighbour or serial-in)
//   q       : stored bit
module shreg_cell
  import univ_shreg_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  enable,
  input  mode_t mode,
  input  logic  d,
  input  logic  shl_in,
  input  logic  shr_in,
  output logic  q
);

  logic q_next;

  always_comb begin
    q_next = q;
    case (mode)
      HOLD:    q_next = q;
      SHL:     q_next = shl_in;
      SHR:     q_next = shr_in;
      LOAD:    q_next = d;
      default: q_next = q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= 1'b0;
    end else if (enable) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/univ_shreg.sv
// Universal shift register: hold, shift-left, shift-right and parallel load,
// gated by enable. Counts shifts since the last load (saturating at WIDTH)
// and flags done once a full word has been serialised.
// Optional build macro: UNIV_SHREG_ROTATE_EN -- shifts rotate instead of
// taking sin_l / sin_r; counting and control are unchanged.
// Ports:
//   clock   : clock, all state updates on posedge
//   reset   : synchronous active-high reset, priority over enable
//   enable  : 1 = act on mode this edge, 0 = hold all state
//   mode    : HOLD / SHL / SHR / LOAD
//   D       : parallel load data
//   sin_l   : serial in, enters bit 0 on SHL
//   sin_r   : serial in, enters bit WIDTH-1 on SHR
//   Q       : register contents
//   sout_l  : Q[WIDTH-1], bit leaving on SHL
//   sout_r  : Q[0], bit leaving on SHR
//   count   : shifts since last LOAD, saturating at WIDTH
//   done    : 1 when the control state is FULL (count == WIDTH)
//   state   : control state, exposed for observation
module univ_shreg
  import univ_shreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  mode_t                           mode,
  input  logic [WIDTH-1:0]                D,
  input  logic                            sin_l,
  input  logic                            sin_r,
  output logic [WIDTH-1:0]                Q,
  output logic                            sout_l,
  output logic                            sout_r,
  output logic [count_bits(WIDTH)-1:0]    count,
  output logic                            done,
  output state_t                          state
);

  localparam int CW = count_bits(WIDTH);

  // Bits entering the word at each end on a shift.
  logic serial_l;
  logic serial_r;

`ifdef UNIV_SHREG_ROTATE_EN
  assign serial_l = Q[WIDTH-1];
  assign serial_r = Q[0];
  // Serial inputs have no function when rotating.
  logic unused_sin;
  assign unused_sin = sin_l ^ sin_r;
`else
  assign serial_l = sin_l;
  assign serial_r = sin_r;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic shl_src;
    logic shr_src;

    if (i == 0) begin : g_lo
      assign shl_src = serial_l;
    end else begin : g_lo_mid
      assign shl_src = Q[i-1];
    end

    if (i == WIDTH - 1) begin : g_hi
      assign shr_src = serial_r;
    end else begin : g_hi_mid
      assign shr_src = Q[i+1];
    end

    shreg_cell u_cell (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .mode   (mode),
      .d      (D[i]),
      .shl_in (shl_src),
      .shr_in (shr_src),
      .q      (Q[i])
    );
  end

  assign sout_l = Q[WIDTH-1];
  assign sout_r = Q[0];
  assign done   = (state == FULL);

  // Control FSM and shift counter. Counting only happens in LOADED: shifts
  // before any load leave count at 0, and in FULL count is already WIDTH.
  // LOAD takes precedence over everything, so a load on the edge that would
  // have completed the word restarts the count instead.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else if (enable) begin
      case (mode)
        LOAD: begin
          state <= LOADED;
          count <= '0;
        end
        SHL, SHR: begin
          if (state == LOADED) begin
            if (count == CW'(WIDTH - 1)) begin
              count <= CW'(WIDTH);
              state <= FULL;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        default: begin
          state <= state;
          count <= count;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_univ_shreg.sv
// Bench for univ_shreg (WIDTH=8). Directed scenarios followed by random
// operations, every edge compared against a reference model that tracks the
// word as an integer and the number of shifts since the last load.
// Honours UNIV_SHREG_ROTATE_EN when the design is built with it.
module tb_univ_shreg;
  import univ_shreg_pkg::*;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clock;
  logic          reset;
  logic          enable;
  mode_t         mode;
  logic [W-1:0]  D;
  logic          sin_l;
  logic          sin_r;
  logic [W-1:0]  Q;
  logic          sout_l;
  logic          sout_r;
  logic [CW-1:0] count;
  logic          done;
  state_t        state;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int unsigned m_q;
  bit          m_loaded;
  int          m_shifts;

  univ_shreg #(.WIDTH(W)) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .mode   (mode),
    .D      (D),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .Q      (Q),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .count  (count),
    .done   (done),
    .state  (state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit en, input int m,
                            input int unsigned d, input bit sl, input bit sr);
    int unsigned mask;
    int unsigned in_bit;
    mask = (1 << W) - 1;
    if (rst) begin
      m_q = 0; m_loaded = 0; m_shifts = 0;
    end else if (en) begin
      case (m)
        1: begin
`ifdef UNIV_SHREG_ROTATE_EN
          in_bit = (m_q >> (W - 1)) & 1;
`else
          in_bit = sl;
`endif
          m_q = ((m_q * 2) + in_bit) & mask;
          if (m_loaded) m_shifts++;
        end
        2: begin
`ifdef UNIV_SHREG_ROTATE_EN
          in_bit = m_q & 1;
`else
          in_bit = sr;
`endif
          m_q = ((m_q / 2) + in_bit * (1 << (W - 1))) & mask;
          if (m_loaded) m_shifts++;
        end
        3: begin
          m_q = d & mask; m_loaded = 1; m_shifts = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    int exp_cnt;
    exp_cnt = !m_loaded ? 0 : (m_shifts > W ? W : m_shifts);
    check({tag, ".q"},      64'(Q),      64'(m_q));
    check({tag, ".sout_l"}, 64'(sout_l), 64'((m_q >> (W - 1)) & 1));
    check({tag, ".sout_r"}, 64'(sout_r), 64'(m_q & 1));
    check({tag, ".count"},  64'(count),  64'(exp_cnt));
    check({tag, ".done"},   64'(done),   64'(m_loaded && m_shifts >= W));
  endtask

  // Driver: one edge with the given inputs, then compare against the model.
  task automatic step(input string tag, input bit rst, input bit en, input int m,
                      input int unsigned d, input bit sl, input bit sr);
    @(negedge clock);
    reset  = rst;
    enable = en;
    mode   = mode_t'(m[1:0]);
    D      = d[W-1:0];
    sin_l  = sl;
    sin_r  = sr;
    @(posedge clock);
    model_edge(rst, en, m, d, sl, sr);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mode = HOLD; D = '0; sin_l = 1'b0; sin_r = 1'b0;
    m_q = 0; m_loaded = 0; m_shifts = 0;

    // 1. reset
    step("rst0", 1, 0, 0, 0, 0, 0);
    step("rst1", 1, 0, 0, 0, 0, 0);
    check("rst.q",     64'(Q), 64'h0);
    check("rst.count", 64'(count), 64'h0);
    check("rst.done",  64'(done), 64'h0);
    check("rst.state", 64'(state), 64'(IDLE));
    step("idle_hold", 0, 1, 0, 0, 0, 0);

    // 2. serialise A5 out of the left end
    step("t2_load", 0, 1, 3, 32'hA5, 0, 0);
    for (int i = 0; i < W; i++) step("t2_shl", 0, 1, 1, 0, 0, 0);
`ifndef UNIV_SHREG_ROTATE_EN
    check("t2.q_end", 64'(Q), 64'h00);
`else
    check("t2.q_end", 64'(Q), 64'hA5);
`endif
    check("t2.done_end", 64'(done), 64'h1);
    check("t2.count_end", 64'(count), 64'(W));
    step("t2_full_shr", 0, 1, 2, 0, 0, 1);
    check("t2.full_done", 64'(done), 64'h1);

    // 3. enable low holds everything
    step("t3_load", 0, 1, 3, 32'h81, 0, 0);
    for (int i = 0; i < 3; i++) step("t3_dis", 0, 0, 2, 32'hFF, 1, 1);
    check("t3.hold_q", 64'(Q), 64'h81);
    step("t3_shr", 0, 1, 2, 0, 0, 1);
`ifndef UNIV_SHREG_ROTATE_EN
    check("t3.q", 64'(Q), 64'hC0);
`endif
    check("t3.count", 64'(count), 64'h1);

    // 4. load on the edge that would complete the word
    step("t4_load", 0, 1, 3, 32'h0F, 0, 0);
    for (int i = 0; i < W - 1; i++) step("t4_shr", 0, 1, 2, 0, 0, 0);
    step("t4_reload", 0, 1, 3, 32'h33, 0, 0);
    check("t4.q", 64'(Q), 64'h33);
    check("t4.count", 64'(count), 64'h0);
    check("t4.done", 64'(done), 64'h0);

    // 5. reset mid-serialisation
    step("t5_load", 0, 1, 3, 32'hFF, 0, 0);
    for (int i = 0; i < 4; i++) step("t5_shl", 0, 1, 1, 0, 0, 0);
    step("t5_rst", 1, 1, 1, 0, 0, 0);
    check("t5.state", 64'(state), 64'(IDLE));
    step("t5_idle_shl", 0, 1, 1, 0, 1, 0);

`ifdef UNIV_SHREG_ROTATE_EN
    // 6. rotate
    step("t6_load", 0, 1, 3, 32'h81, 0, 0);
    step("t6_shl", 0, 1, 1, 0, 0, 0);
    check("t6.q1", 64'(Q), 64'h03);
    for (int i = 0; i < W - 1; i++) step("t6_shl", 0, 1, 1, 0, 0, 0);
    check("t6.q8", 64'(Q), 64'h81);
    check("t6.done", 64'(done), 64'h1);
`endif

    // Random operations
    for (int n = 0; n < 400; n++) begin
      step("rand",
           $urandom_range(0, 49) == 0,
           $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 3)),
           $urandom_range(0, 255),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
